uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Receive-side counterpart of the team's UART transmitter. It deserialises 8N1 frames at 115200 baud (217 clocks/bit at 25 MHz) from the RX pin into a one-byte holding buffer. The CPU reads the buffer through the same 16-bit memory-mapped I/O convention the transmitter uses: out[15] is a status flag and out[7:0] is the data. It sits directly downstream of the transmitter on the serial link, and its TX-to-RX loopback is the team's link self-test.

Parameters:
CLOCKS_PER_BIT, 217, clock cycles per bit period. Must be ≥ 4.
HALF_BIT, CLOCKS_PER_BIT/2 (=108), cycles from the start-edge detect to the start-bit centre sample.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
RX  in  1  serial line, asynchronous, idle high
clear  in  1  CPU acknowledge: empties the buffer and clears the error flags
out  out  16  [15]=empty (1 = no byte), [14]=framing error, [13]=overrun, [12:8]=0, [7:0]=last received byte

Behaviour:
- Reset (async, active-high). Values: sync FFs=1, state=IDLE, counters=0, shift reg=0, data=0, empty=1, ferr=0, ovr=0. Resulting out = 16'h8000.
- Reset mid-frame aborts the frame. No partial byte is ever committed.
- RX passes through a 2-FF synchroniser to give rx_s. All decisions use rx_s only.
- Bits are LSB first. Data is shifted into shift_reg[7] with a right shift.
- State IDLE:
  - If rx_s=0: go to START with cnt=0.
- State START:
  - If cnt≠HALF_BIT-1: cnt++.
  - Else if rx_s=0: go to DATA with cnt=0, bitn=0.
  - Else (glitch shorter than half a bit): go to IDLE. No flags change.
- State DATA:
  - If cnt≠CLOCKS_PER_BIT-1: cnt++.
  - Else: sample rx_s into the shift register and set cnt=0.
  - After the sample with bitn=7, go to STOP. Otherwise bitn++.
- State STOP, when cnt=CLOCKS_PER_BIT-1 (otherwise cnt++):
  - rx_s=1 and the buffer is empty (after any same-cycle clear): data<=shift reg, empty<=0, go to IDLE.
  - rx_s=1 and the buffer is full: byte is dropped, data keeps its old value, ovr<=1, go to IDLE.
  - rx_s=0: ferr<=1, byte is dropped, go to BREAK.
- State BREAK:
  - Wait for rx_s=1, then go to IDLE. This prevents re-triggering on a held-low line.
- clear=1: empty<=1, ferr<=0, ovr<=0 on that edge. The receive FSM is unaffected.
- Simultaneous clear and successful commit on the same edge: clear applies first. Net result: empty=0, data=new byte, ovr=0, ferr=0.
- Simultaneous clear and framing error on the same edge: ferr=1 (the error wins).
- Latency: count the first rising edge that samples RX low as edge 1.
  - The START→DATA transition happens at edge 111.
  - Data bit n is sampled at edge 111+217·(n+1).
  - The stop bit is sampled and the byte committed at edge 2064. out reflects the commit immediately after that edge.
- The receiver is ready for the next start bit the cycle after the commit, so back-to-back frames are supported.
- out is purely registered. There are no combinational paths from RX or clear to out.

Test Plan:
- Reset: assert reset mid-frame while RX is toggling → out=16'h8000 immediately (async). After release, with RX idle, out stays 16'h8000 and nothing is committed.
- Single byte: drive 8N1 0xA5 at 217 clk/bit → out[15] falls exactly at edge 2064, out=16'h00A5. Assert clear → out=16'h80A5 (empty set, data retained).
- Back-to-back and overrun: send 0x3C then 0xC3 with no clear → out=16'h203C (ovr=1, first byte kept). Clear, then send 0x7E → out=16'h007E.
- Framing error: send 0x55 with the stop bit driven low, then RX held low for 1000 clk, then high → out=16'hC000 (empty=1, ferr=1) and no new start is detected while RX is low. A subsequent 0x81 gives out[7:0]=0x81, and ferr stays 1 until clear.
- Glitch rejection: pulse RX low for 50 clk → state returns to IDLE, out unchanged. Pulse low for 120 clk, treated as start, with the rest high → byte 0xFF committed.
- Loopback and boundary: connect the transmitter's TX to RX and send 0x00, 0xFF, 0x01, 0x80 with clear asserted on the exact commit edge of the second byte → every byte is received correctly, and on the coincident edge out[15]=0 with ovr=0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte holding buffer.
// The CPU-facing word is out = {empty, framing_err, overrun, 5'b0, data}.
// Every bit of out comes straight from a flop.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 217,
    parameter int HALF_BIT       = CLOCKS_PER_BIT / 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RX,
    input  logic        clear,
    output logic [15:0] out
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] LAST_BIT_CNT  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_HALF_CNT = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitn;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_empty;
    logic          r_ferr;
    logic          r_ovr;
    logic          w_rx_s;

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser for the asynchronous RX line (idles high)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM plus buffer/flag updates; clear is applied first so a
    // same-edge commit or framing error overrides it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bitn  <= 3'd0;
            r_shift <= 8'd0;
            r_data  <= 8'd0;
            r_empty <= 1'b1;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (clear) begin
                r_empty <= 1'b1;
                r_ferr  <= 1'b0;
                r_ovr   <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt != LAST_HALF_CNT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!w_rx_s) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        r_bitn  <= 3'd0;
                    end else begin
                        // Low pulse shorter than half a bit: ignore it
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (r_cnt != LAST_BIT_CNT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_cnt   <= '0;
                        if (r_bitn == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bitn <= r_bitn + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (r_cnt != LAST_BIT_CNT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_rx_s) begin
                        if (r_empty || clear) begin
                            r_data  <= r_shift;
                            r_empty <= 1'b0;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_ferr  <= 1'b1;
                        r_state <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    // Hold off until the line returns high so a stuck-low
                    // line does not look like a stream of start bits
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out = {r_empty, r_ferr, r_ovr, 5'b00000, r_data};

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a behavioural 8N1 transmitter.
module tb_uart_rx;

    localparam int CPB = 217;

    logic        clk;
    logic        reset;
    logic        RX;
    logic        clear;
    logic [15:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .RX    (RX),
        .clear (clear),
        .out   (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Transmit one frame; called on a falling clock edge, returns on one.
    // RX is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (CPB) @(negedge clk);
        end
        RX = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        RX    = 1'b1;
        clear = 1'b0;
        #2 check("reset_async", out, 16'h8000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_idle", out, 16'h8000);

        // Single byte, commit edge located exactly
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (2063) @(posedge clk);
                #1 check("a5_before_commit", {15'd0, out[15]}, 16'h0001);
                @(posedge clk);
                #1 check("a5_commit_edge", out, 16'h00A5);
            end
        join
        pulse_clear();
        check("a5_clear", out, 16'h80A5);

        // Reset in the middle of a frame
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (500) @(negedge clk);
                #3 reset = 1'b1;
                #1 check("reset_midframe", out, 16'h8000);
            end
        join
        reset = 1'b0;
        repeat (3000) @(negedge clk);
        check("reset_no_commit", out, 16'h8000);

        // Back-to-back frames with overrun
        send_frame(8'h3C, 1'b1);
        check("ovr_first", out, 16'h003C);
        send_frame(8'hC3, 1'b1);
        check("ovr_set", out, 16'h203C);
        pulse_clear();
        check("ovr_clear", out, 16'h803C);
        send_frame(8'h7E, 1'b1);
        check("after_ovr", out, 16'h007E);

        // Framing error followed by a held-low line
        do_reset();
        send_frame(8'h55, 1'b0);
        RX = 1'b0;
        repeat (1000) @(negedge clk);
        check("ferr_held_low", out, 16'hC000);
        RX = 1'b1;
        repeat (500) @(negedge clk);
        check("ferr_line_idle", out, 16'hC000);
        send_frame(8'h81, 1'b1);
        check("ferr_sticky", out, 16'h4081);
        pulse_clear();
        check("ferr_clear", out, 16'h8081);

        // Glitch rejection and a long low pulse taken as a start bit
        RX = 1'b0;
        repeat (50) @(negedge clk);
        RX = 1'b1;
        repeat (3000) @(negedge clk);
        check("glitch_short", out, 16'h8081);
        RX = 1'b0;
        repeat (120) @(negedge clk);
        RX = 1'b1;
        repeat (2200) @(negedge clk);
        check("glitch_long_ff", out, 16'h00FF);

        // Loopback sequence with clear on the exact commit edge of byte 2
        pulse_clear();
        check("loop_pre_clear", out, 16'h80FF);
        send_frame(8'h00, 1'b1);
        check("loop_00", out, 16'h0000);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (2063) @(posedge clk);
                @(negedge clk);
                clear = 1'b1;
                @(posedge clk);
                #1 check("loop_ff_coincident", out, 16'h00FF);
                clear = 1'b0;
            end
        join
        pulse_clear();
        send_frame(8'h01, 1'b1);
        check("loop_01", out, 16'h0001);
        pulse_clear();
        send_frame(8'h80, 1'b1);
        check("loop_80", out, 16'h0080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
